fir_ctrl: RTL and testbench

- Sample-rate sequencer that drives the adaptive FIR engine from the controller side.
- Accepts one input tuple per sample over a valid/ready handshake: reference x, primary a, error e.
- Computes the LMS step weight_adjust = mu*e in Q15, issues a single fir_go, waits for done, captures out_sample, and presents it downstream on a valid/ready handshake.
- Includes a watchdog on the FIR completion and status counters.

---
 rtl/fir_ctrl_if.sv | 33 +++
 rtl/fir_ctrl.sv | 133 +++++++++++++
 tb/tb_fir_ctrl.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_ctrl_if.sv
// Controller-side bundle: upstream tuple handshake, FIR engine strobes and the
// downstream sample handshake. master = the sequencer, slave = its surroundings.
interface fir_ctrl_if;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_x;
  logic [15:0] s_a;
  logic [15:0] s_err;
  logic [15:0] mu;
  logic        adapt_en;
  logic        fir_go;
  logic [15:0] fir_x;
  logic [15:0] fir_a;
  logic [15:0] fir_wadj;
  logic [15:0] fir_out_sample;
  logic        fir_out_valid;
  logic        fir_done;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;

  modport master (
    input  s_valid, s_x, s_a, s_err, mu, adapt_en,
    input  fir_out_sample, fir_out_valid, fir_done, m_ready,
    output s_ready, fir_go, fir_x, fir_a, fir_wadj, m_valid, m_data
  );

  modport slave (
    output s_valid, s_x, s_a, s_err, mu, adapt_en,
    output fir_out_sample, fir_out_valid, fir_done, m_ready,
    input  s_ready, fir_go, fir_x, fir_a, fir_wadj, m_valid, m_data
  );
endinterface

// File: rtl/fir_ctrl.sv
// Sample-rate sequencer for the adaptive FIR: accepts a tuple, forms the Q15 LMS
// step mu*e, fires the engine once, waits (with watchdog) and hands the result on.
module fir_ctrl #(
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  fir_ctrl_if.master       bus,
  output logic             busy,
  output logic             timeout_pulse,
  output logic [7:0]       timeout_cnt,
  output logic [CNT_W-1:0] sample_cnt
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] CALC = 3'd1;
  localparam logic [2:0] GO   = 3'd2;
  localparam logic [2:0] WAIT = 3'd3;
  localparam logic [2:0] OUT  = 3'd4;

  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 1);

  logic [2:0]         state_q, state_d;
  logic               readyEn_q;
  logic [15:0]        x_q, a_q;
  logic signed [15:0] mu_q, err_q;
  logic               adapt_q;
  logic [15:0]        wdog_q, wdog_d;
  logic [15:0]        mData_q, mData_d;
  logic [7:0]         timeoutCnt_q, timeoutCnt_d;
  logic [CNT_W-1:0]   sampleCnt_q, sampleCnt_d;
  logic               accept;
  logic               abort;
  logic signed [31:0] prod;
  logic signed [31:0] shifted;
  logic [15:0]        wadjSat;

  assign accept = bus.s_valid && bus.s_ready;
  assign abort  = (state_q == WAIT) && !bus.fir_done && (wdog_q == WDOG_LAST);

  // Floor-shifted Q15 product; only (-1)*(-1) can exceed the positive range.
  always_comb begin
    prod    = 32'(mu_q) * 32'(err_q);
    shifted = prod >>> 15;
    if (shifted > 32'sd32767) begin
      wadjSat = 16'h7FFF;
    end else if (shifted < -32'sd32768) begin
      wadjSat = 16'h8000;
    end else begin
      wadjSat = shifted[15:0];
    end
  end

  always_comb begin
    state_d      = state_q;
    wdog_d       = wdog_q;
    mData_d      = mData_q;
    timeoutCnt_d = timeoutCnt_q;
    sampleCnt_d  = sampleCnt_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = CALC;
      end
      CALC: state_d = GO;
      GO: begin
        wdog_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        wdog_d = wdog_q + 16'd1;
        if (bus.fir_out_valid) mData_d = bus.fir_out_sample;
        if (bus.fir_done) begin
          state_d = OUT;
        end else if (abort) begin
          state_d = IDLE;
          if (timeoutCnt_q != 8'hFF) timeoutCnt_d = timeoutCnt_q + 8'd1;
        end
      end
      OUT: begin
        if (bus.m_ready) begin
          sampleCnt_d = sampleCnt_q + 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // readyEn_q keeps s_ready low while reset is held and for the first edge after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      readyEn_q    <= 1'b0;
      x_q          <= '0;
      a_q          <= '0;
      mu_q         <= '0;
      err_q        <= '0;
      adapt_q      <= 1'b0;
      wdog_q       <= '0;
      mData_q      <= '0;
      timeoutCnt_q <= '0;
      sampleCnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      readyEn_q    <= 1'b1;
      wdog_q       <= wdog_d;
      mData_q      <= mData_d;
      timeoutCnt_q <= timeoutCnt_d;
      sampleCnt_q  <= sampleCnt_d;
      if (accept) begin
        x_q     <= bus.s_x;
        a_q     <= bus.s_a;
        mu_q    <= bus.mu;
        err_q   <= bus.s_err;
        adapt_q <= bus.adapt_en;
      end
    end
  end

  assign bus.s_ready  = readyEn_q && (state_q == IDLE);
  assign bus.fir_go   = (state_q == GO);
  assign bus.fir_x    = x_q;
  assign bus.fir_a    = a_q;
  assign bus.fir_wadj = adapt_q ? wadjSat : 16'h0000;
  assign bus.m_valid  = (state_q == OUT);
  assign bus.m_data   = mData_q;
  assign busy          = (state_q != IDLE);
  assign timeout_pulse = abort;
  assign timeout_cnt   = timeoutCnt_q;
  assign sample_cnt    = sampleCnt_q;

endmodule

// File: tb/tb_fir_ctrl.sv
// Randomised bench for fir_ctrl: a behavioural FIR responder plus a scoreboard
// that predicts every fir_go, output sample, counter and watchdog abort.
module tb_fir_ctrl;

  localparam int TIMEOUT = 40;
  localparam int CNT_W   = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fir_ctrl_if busIf ();

  logic             busy;
  logic             timeoutPulse;
  logic [7:0]       timeoutCnt;
  logic [CNT_W-1:0] sampleCnt;

  fir_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (busIf),
    .busy          (busy),
    .timeout_pulse (timeoutPulse),
    .timeout_cnt   (timeoutCnt),
    .sample_cnt    (sampleCnt)
  );

  logic        sValid = 1'b0;
  logic [15:0] sX = '0, sA = '0, sErr = '0, sMu = '0;
  logic        sAdapt = 1'b0;
  logic        mReadyMain = 1'b1, randReady = 1'b0, rr = 1'b1;
  logic        rDone = 1'b0, rValid = 1'b0, sDone = 1'b0;
  logic [15:0] rSample = '0;

  assign busIf.s_valid        = sValid;
  assign busIf.s_x            = sX;
  assign busIf.s_a            = sA;
  assign busIf.s_err          = sErr;
  assign busIf.mu             = sMu;
  assign busIf.adapt_en       = sAdapt;
  assign busIf.m_ready        = mReadyMain & (randReady ? rr : 1'b1);
  assign busIf.fir_done       = rDone | sDone;
  assign busIf.fir_out_valid  = rValid | sDone;
  assign busIf.fir_out_sample = sDone ? 16'hDEAD : rSample;

  typedef struct {
    int          at;
    logic [15:0] x;
    logic [15:0] a;
    logic [15:0] w;
  } goEnt_t;

  goEnt_t      goQ[$];
  logic [15:0] outQ[$];
  int total = 0, bad = 0;
  int cyc = 0;
  int goCount = 0;
  int expCnt = 0, expToCnt = 0, expTimeoutAt = -1, expMvalidAt = -1;
  int epoch = 0;
  int firLat = 5, firMode = 0;
  logic respondEn = 1'b1, forcedVal = 1'b0;
  logic [15:0] forcedData = '0;
  logic prevMv = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk);
    #1 rr = 1'($urandom_range(0, 1));
  end

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Q15 step from plain integer arithmetic: floor(mu*e / 2^15), clamped.
  function automatic logic [15:0] expWadj(logic [15:0] m, logic [15:0] e, logic en);
    int mi, ei, p, q;
    if (!en) return 16'h0000;
    mi = $signed(m);
    ei = $signed(e);
    p  = mi * ei;
    q  = p / 32768;
    if (p < 0 && (p % 32768) != 0) q = q - 1;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return q[15:0];
  endfunction

  // FIR engine model: one job per fir_go, result after firLat cycles or never.
  initial forever begin
    int          myEpoch;
    logic [15:0] val;
    logic [15:0] junk;
    @(negedge clk);
    if (rst_n && busIf.fir_go) begin
      myEpoch = epoch;
      if (respondEn) begin
        val  = forcedVal ? forcedData : 16'($urandom);
        junk = ~val;
        outQ.push_back(val);
        for (int k = 1; k <= firLat; k++) begin
          @(posedge clk);
          #1;
          rDone  = 1'b0;
          rValid = 1'b0;
          if (epoch == myEpoch) begin
            if (firMode != 0 && k == firLat - 2) begin
              rValid  = 1'b1;
              rSample = (firMode == 1) ? val : junk;
            end
            if (k == firLat) begin
              rDone       = 1'b1;
              rValid      = (firMode != 1);
              rSample     = (firMode == 1) ? junk : val;
              expMvalidAt = cyc + 1;
            end
          end
        end
        @(posedge clk);
        #1;
        rDone  = 1'b0;
        rValid = 1'b0;
      end else begin
        expTimeoutAt = cyc + TIMEOUT;
      end
    end
  end

  // Scoreboard compare on every falling edge while out of reset.
  always @(negedge clk) begin : compare
    goEnt_t ent;
    if (rst_n) begin
      checkOutput("timeout_cnt", timeoutCnt, expToCnt);
      if (timeoutPulse) begin
        checkOutput("timeout_at", cyc, expTimeoutAt);
        expTimeoutAt = -1;
        if (expToCnt < 255) expToCnt++;
      end else if (cyc == expTimeoutAt) begin
        checkOutput("timeout_missing", timeoutPulse, 1);
        expTimeoutAt = -1;
      end
      if (busIf.fir_go) begin
        goCount++;
        if (goQ.size() == 0) begin
          checkOutput("go_unexpected", busIf.fir_go, 0);
        end else begin
          ent = goQ.pop_front();
          checkOutput("go_cycle", cyc, ent.at);
          checkOutput("fir_x", busIf.fir_x, ent.x);
          checkOutput("fir_a", busIf.fir_a, ent.a);
          checkOutput("fir_wadj", busIf.fir_wadj, ent.w);
        end
      end
      if (busIf.m_valid) begin
        checkOutput("s_ready_stall", busIf.s_ready, 0);
        checkOutput("busy_out", busy, 1);
        if (outQ.size() == 0) begin
          checkOutput("mvalid_unexpected", busIf.m_valid, 0);
        end else begin
          if (!prevMv) checkOutput("mvalid_cycle", cyc, expMvalidAt);
          checkOutput("m_data", busIf.m_data, outQ[0]);
          if (busIf.m_ready) begin
            checkOutput("sample_cnt", sampleCnt, expCnt);
            void'(outQ.pop_front());
            expCnt++;
          end
        end
      end
      prevMv = busIf.m_valid;
      if (sValid && busIf.s_ready)
        goQ.push_back('{cyc + 2, sX, sA, expWadj(sMu, sErr, sAdapt)});
    end else begin
      prevMv = 1'b0;
    end
  end

  // Called in the posedge+#1 phase; returns in that phase after the accept.
  task automatic applyStimulus(logic [15:0] x, logic [15:0] a, logic [15:0] e,
                               logic [15:0] m, logic en, logic hold);
    logic accepted;
    accepted = 1'b0;
    sValid = 1'b1;
    sX = x; sA = a; sErr = e; sMu = m; sAdapt = en;
    for (int i = 0; i < 500 && !accepted; i++) begin
      @(negedge clk);
      accepted = busIf.s_ready;
    end
    if (!accepted) checkOutput("accept_timeout", accepted, 1);
    @(posedge clk);
    #1;
    if (!hold) sValid = 1'b0;
  endtask

  task automatic waitSamples(int target, int budget);
    for (int i = 0; i < budget && expCnt < target; i++) @(negedge clk);
    if (expCnt < target) checkOutput("wait_samples", expCnt, target);
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic checkAllZero(string tag);
    checkOutput({tag, "_s_ready"}, busIf.s_ready, 0);
    checkOutput({tag, "_fir_go"}, busIf.fir_go, 0);
    checkOutput({tag, "_fir_x"}, busIf.fir_x, 0);
    checkOutput({tag, "_fir_a"}, busIf.fir_a, 0);
    checkOutput({tag, "_fir_wadj"}, busIf.fir_wadj, 0);
    checkOutput({tag, "_m_valid"}, busIf.m_valid, 0);
    checkOutput({tag, "_m_data"}, busIf.m_data, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_tpulse"}, timeoutPulse, 0);
    checkOutput({tag, "_tcnt"}, timeoutCnt, 0);
    checkOutput({tag, "_scnt"}, sampleCnt, 0);
  endtask

  initial begin
    int          g0;
    logic        seen;
    logic [15:0] md;

    repeat (3) @(posedge clk);
    #1;
    checkAllZero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("s_ready_idle", busIf.s_ready, 1);
    @(posedge clk);
    #1;

    $display("[TB] basic sample");
    forcedVal = 1'b1; forcedData = 16'h1234; firLat = 20; firMode = 0;
    applyStimulus(16'h4000, 16'h0100, 16'h2000, 16'h4000, 1'b1, 1'b0);
    waitSamples(1, 200);
    checkOutput("basic_wadj", busIf.fir_wadj, 16'h1000);
    checkOutput("basic_mdata", busIf.m_data, 16'h1234);
    checkOutput("basic_cnt", sampleCnt, 1);
    forcedVal = 1'b0;

    $display("[TB] arithmetic edges");
    firLat = 4;
    applyStimulus(16'($urandom), 16'($urandom), 16'h8000, 16'h8000, 1'b1, 1'b0);
    waitSamples(2, 200);
    checkOutput("sat_wadj", busIf.fir_wadj, 16'h7FFF);
    applyStimulus(16'($urandom), 16'($urandom), 16'hFFFF, 16'h7FFF, 1'b1, 1'b0);
    waitSamples(3, 200);
    checkOutput("floor_wadj", busIf.fir_wadj, 16'hFFFF);
    applyStimulus(16'($urandom), 16'($urandom), 16'h7FFF, 16'h7FFF, 1'b0, 1'b0);
    waitSamples(4, 200);
    checkOutput("freeze_wadj", busIf.fir_wadj, 16'h0000);

    $display("[TB] backpressure");
    mReadyMain = 1'b0;
    applyStimulus(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'b1, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = busIf.m_valid;
    end
    checkOutput("bp_mvalid_seen", seen, 1);
    g0 = goCount;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checkOutput("bp_s_ready", busIf.s_ready, 0);
    end
    checkOutput("bp_no_go", goCount, g0);
    @(posedge clk);
    #1 mReadyMain = 1'b1;
    waitSamples(5, 50);
    checkOutput("bp_cnt", sampleCnt, 5);

    $display("[TB] watchdog");
    respondEn = 1'b0;
    applyStimulus(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'b1, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < TIMEOUT + 20 && !seen; i++) begin
      @(negedge clk);
      seen = timeoutPulse;
    end
    checkOutput("wd_pulse_seen", seen, 1);
    @(negedge clk);
    checkOutput("wd_cnt", timeoutCnt, 1);
    checkOutput("wd_busy", busy, 0);
    md = busIf.m_data;
    @(posedge clk);
    #1 sDone = 1'b1;
    @(posedge clk);
    #1 sDone = 1'b0;
    @(negedge clk);
    checkOutput("late_busy", busy, 0);
    checkOutput("late_mvalid", busIf.m_valid, 0);
    checkOutput("late_mdata", busIf.m_data, md);
    respondEn = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'b1, 1'b0);
    waitSamples(6, 200);
    checkOutput("wd_next_cnt", sampleCnt, 6);

    $display("[TB] back-to-back stream");
    g0 = goCount;
    for (int i = 0; i < 10; i++) begin
      firLat  = $urandom_range(3, 12);
      firMode = $urandom_range(0, 2);
      applyStimulus(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                    1'($urandom_range(0, 1)), (i != 9));
    end
    waitSamples(16, 400);
    checkOutput("stream_go", goCount - g0, 10);
    checkOutput("stream_cnt", sampleCnt, 16);
    sDone = 1'b1;
    @(posedge clk);
    #1 sDone = 1'b0;
    @(negedge clk);
    checkOutput("stray_busy", busy, 0);
    checkOutput("stray_mvalid", busIf.m_valid, 0);
    @(posedge clk);
    #1;

    $display("[TB] random stall phase");
    randReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      firLat  = $urandom_range(3, 15);
      firMode = $urandom_range(0, 2);
      applyStimulus(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    sValid = 1'b0;
    waitSamples(24, 600);
    randReady = 1'b0;

    $display("[TB] reset mid-wait");
    firLat = 30; firMode = 0;
    g0 = goCount;
    applyStimulus(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'b1, 1'b0);
    for (int i = 0; i < 20 && goCount == g0; i++) @(negedge clk);
    checkOutput("mr_go_seen", goCount, g0 + 1);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    epoch++;
    #1;
    checkAllZero("midreset");
    goQ.delete();
    outQ.delete();
    expCnt = 0; expToCnt = 0; expTimeoutAt = -1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    checkOutput("mr_s_ready", busIf.s_ready, 1);
    checkOutput("mr_busy", busy, 0);
    firLat = 5;
    @(posedge clk);
    #1;
    applyStimulus(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'b1, 1'b0);
    waitSamples(1, 200);
    checkOutput("mr_cnt", sampleCnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
